// File: rtl/rs_pkg.sv
// GF(2^8) helpers shared by the Reed-Solomon syndrome path: field constants,
// symbol type, alpha-power table, constant-friendly multiply and FSM states.
package rs_pkg;

  localparam int RS_SYM_W    = 8;
  localparam int FIELD_SIZE  = 1 << RS_SYM_W;
  localparam int FIELD_ORDER = FIELD_SIZE - 1;
  localparam logic [RS_SYM_W:0] FIELD_POLY = 9'h11D;

  typedef logic [RS_SYM_W-1:0] sym_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } rs_state_e;

  // Multiply by alpha (x): shift left, reduce by the field polynomial on overflow.
  function automatic sym_t gf_xtime(input sym_t a);
    return {a[RS_SYM_W-2:0], 1'b0} ^ (a[RS_SYM_W-1] ? FIELD_POLY[RS_SYM_W-1:0] : '0);
  endfunction

  function automatic logic [FIELD_ORDER*RS_SYM_W-1:0] build_alpha_table();
    logic [FIELD_ORDER*RS_SYM_W-1:0] tbl;
    sym_t p;
    tbl = '0;
    p   = sym_t'(1);
    for (int e = 0; e < FIELD_ORDER; e++) begin
      tbl[e*RS_SYM_W +: RS_SYM_W] = p;
      p = gf_xtime(p);
    end
    return tbl;
  endfunction

  // alpha^0 .. alpha^(FIELD_ORDER-1), entry e in slice e.
  localparam logic [FIELD_ORDER*RS_SYM_W-1:0] ALPHA_TABLE = build_alpha_table();

  function automatic sym_t alpha_pow(input int e);
    return ALPHA_TABLE[(e % FIELD_ORDER)*RS_SYM_W +: RS_SYM_W];
  endfunction

  // Shift-and-add multiply; with a constant b it collapses to an XOR network.
  function automatic sym_t gf_mul(input sym_t a, input sym_t b);
    sym_t acc;
    sym_t sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < RS_SYM_W; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = gf_xtime(sh);
    end
    return acc;
  endfunction

endpackage

// File: rtl/gf_const_mult.sv
// Combinational multiply of a GF(2^8) symbol by the constant alpha^EXP.
module gf_const_mult
  import rs_pkg::*;
#(
  parameter int EXP = 1
) (
  input  logic [RS_SYM_W-1:0] sym_i,
  output logic [RS_SYM_W-1:0] sym_o
);

  localparam sym_t COEF = alpha_pow(EXP);

  assign sym_o = gf_mul(sym_i, COEF);

endmodule

// File: rtl/rs_syndrome_calc.sv
// Reed-Solomon syndrome calculator: Horner evaluation of each received frame at
// alpha^1..alpha^(2T). Optional short-frame flag enabled by RS_SYNDROME_LEN_CHECK_EN.
module rs_syndrome_calc
  import rs_pkg::*;
#(
  parameter int SYM_W    = RS_SYM_W,
  parameter int CODE_LEN = 16,
  parameter int T        = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   codewordValidPort,
  input  logic [SYM_W-1:0]       codewordInputPort,
  output logic                   syndromeValidPort,
  output logic [2*T*SYM_W-1:0]   syndromeOutputPort,
  output logic                   errorDetectedPort,
  output logic                   lengthErrorPort
);

  localparam int NSYN  = 2 * T;
  localparam int CNT_W = $clog2(CODE_LEN + 1);

  rs_state_e                     state_q, state_d;
  logic [CNT_W-1:0]              count_q, count_d;
  logic [NSYN-1:0][SYM_W-1:0]    acc_q, acc_d, acc_shift, acc_next;
  logic [NSYN*SYM_W-1:0]         syn_q, syn_d;
  logic                          err_q, err_d;
  logic                          syn_valid_q, syn_valid_d;
  logic                          len_err_q, len_err_d;

  for (genvar j = 0; j < NSYN; j++) begin : g_mult
    gf_const_mult #(.EXP(j + 1)) u_mult (
      .sym_i (acc_q[j]),
      .sym_o (acc_shift[j])
    );
  end

  always_comb begin
    for (int j = 0; j < NSYN; j++) begin
      acc_next[j] = acc_shift[j] ^ codewordInputPort;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_d       = acc_q;
    syn_d       = syn_q;
    err_d       = err_q;
    syn_valid_d = 1'b0;
    len_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (codewordValidPort) begin
          for (int j = 0; j < NSYN; j++) acc_d[j] = codewordInputPort;
          count_d = CNT_W'(1);
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (codewordValidPort) begin
          acc_d   = acc_next;
          count_d = count_q + CNT_W'(1);
          // Last symbol: publish straight from the next-state accumulators.
          if (count_q == CNT_W'(CODE_LEN - 1)) begin
            syn_d       = acc_next;
            err_d       = |acc_next;
            syn_valid_d = 1'b1;
            acc_d       = '0;
            count_d     = '0;
            state_d     = ST_IDLE;
          end
        end else begin
          acc_d   = '0;
          count_d = '0;
          state_d = ST_IDLE;
`ifdef RS_SYNDROME_LEN_CHECK_EN
          len_err_d = 1'b1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      acc_q       <= '0;
      syn_q       <= '0;
      err_q       <= 1'b0;
      syn_valid_q <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      syn_q       <= syn_d;
      err_q       <= err_d;
      syn_valid_q <= syn_valid_d;
      len_err_q   <= len_err_d;
    end
  end

  assign syndromeValidPort  = syn_valid_q;
  assign syndromeOutputPort = syn_q;
  assign errorDetectedPort  = err_q;
  assign lengthErrorPort    = len_err_q;

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Directed bench for rs_syndrome_calc (SYM_W=8, CODE_LEN=16, T=2) with
// hand-computed GF(2^8)/0x11D syndromes.
module tb_rs_syndrome_calc;

  logic        clock = 1'b0;
  logic        reset;
  logic        codewordValidPort;
  logic [7:0]  codewordInputPort;
  logic        syndromeValidPort;
  logic [31:0] syndromeOutputPort;
  logic        errorDetectedPort;
  logic        lengthErrorPort;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] frame [16];
  logic       exp_len_err;

  rs_syndrome_calc dut (
    .clock              (clock),
    .reset              (reset),
    .codewordValidPort  (codewordValidPort),
    .codewordInputPort  (codewordInputPort),
    .syndromeValidPort  (syndromeValidPort),
    .syndromeOutputPort (syndromeOutputPort),
    .errorDetectedPort  (errorDetectedPort),
    .lengthErrorPort    (lengthErrorPort)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    @(negedge clock);
    codewordValidPort = v;
    codewordInputPort = d;
  endtask

  task automatic set_impulse(input int pos, input logic [7:0] val);
    for (int i = 0; i < 16; i++) frame[i] = 8'h00;
    frame[pos] = val;
  endtask

  task automatic send_frame();
    for (int i = 0; i < 16; i++) drive(1'b1, frame[i]);
  endtask

  task automatic check_result(input string tag, input logic [31:0] exp_syn, input logic exp_err);
    drive(1'b0, 8'h00);
    check({tag, "_valid"}, 32'(syndromeValidPort), 32'd1);
    check({tag, "_syn"},   syndromeOutputPort,      exp_syn);
    check({tag, "_err"},   32'(errorDetectedPort),  32'(exp_err));
    check({tag, "_lenerr"}, 32'(lengthErrorPort),   32'd0);
    drive(1'b0, 8'h00);
    check({tag, "_valid_1cyc"}, 32'(syndromeValidPort), 32'd0);
    check({tag, "_syn_held"},   syndromeOutputPort,      exp_syn);
  endtask

  initial begin
`ifdef RS_SYNDROME_LEN_CHECK_EN
    exp_len_err = 1'b1;
`else
    exp_len_err = 1'b0;
`endif
    reset = 1'b1;
    codewordValidPort = 1'b0;
    codewordInputPort = 8'h00;
    repeat (3) @(negedge clock);
    check("rst_valid",  32'(syndromeValidPort), 32'd0);
    check("rst_syn",    syndromeOutputPort,      32'd0);
    check("rst_err",    32'(errorDetectedPort),  32'd0);
    check("rst_lenerr", 32'(lengthErrorPort),    32'd0);
    reset = 1'b0;

    // All-zero frame.
    set_impulse(0, 8'h00);
    send_frame();
    check_result("zero", 32'h0000_0000, 1'b0);

    // r(x) = 1: every syndrome is 1.
    set_impulse(15, 8'h01);
    send_frame();
    check_result("deg0", 32'h0101_0101, 1'b1);

    // r(x) = x^15: S_j = alpha^(15j) = 26, 60, C1, B9.
    set_impulse(0, 8'h01);
    send_frame();
    check_result("deg15", 32'hB9C1_6026, 1'b1);

    // (x^5 + 1) * g(x), g = x^4 + 1E x^3 + D8 x^2 + E7 x + 74.
    for (int i = 0; i < 6; i++) frame[i] = 8'h00;
    frame[6]  = 8'h01; frame[7]  = 8'h1E; frame[8]  = 8'hD8; frame[9]  = 8'hE7; frame[10] = 8'h74;
    frame[11] = 8'h01; frame[12] = 8'h1E; frame[13] = 8'hD8; frame[14] = 8'hE7; frame[15] = 8'h74;
    send_frame();
    check_result("codeword", 32'h0000_0000, 1'b0);

    // Error 0x55 on the degree-0 symbol: every syndrome is 0x55.
    frame[15] = frame[15] ^ 8'h55;
    send_frame();
    check_result("codeword_err", 32'h5555_5555, 1'b1);

    // Back-to-back: deg-0 impulse frame followed immediately by deg-15 impulse frame.
    set_impulse(15, 8'h01);
    send_frame();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, (i == 0) ? 8'h01 : 8'h00);
      if (i == 0) begin
        check("b2b_a_valid", 32'(syndromeValidPort), 32'd1);
        check("b2b_a_syn",   syndromeOutputPort,      32'h0101_0101);
        check("b2b_a_err",   32'(errorDetectedPort),  32'd1);
      end else begin
        check("b2b_gap_valid", 32'(syndromeValidPort), 32'd0);
        check("b2b_gap_syn",   syndromeOutputPort,      32'h0101_0101);
      end
    end
    check_result("b2b_b", 32'hB9C1_6026, 1'b1);

    // Short frame: 7 symbols then valid drops.
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h33);
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);
    check("short_lenerr", 32'(lengthErrorPort),    32'(exp_len_err));
    check("short_valid",  32'(syndromeValidPort),  32'd0);
    check("short_syn",    syndromeOutputPort,      32'hB9C1_6026);
    check("short_err",    32'(errorDetectedPort),  32'd1);
    drive(1'b0, 8'h00);
    check("short_lenerr_1cyc", 32'(lengthErrorPort), 32'd0);

    // Reset in the middle of a frame.
    for (int i = 0; i < 6; i++) drive(1'b1, 8'h77);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    codewordValidPort = 1'b0;
    codewordInputPort = 8'h00;
    check("midrst_valid",  32'(syndromeValidPort), 32'd0);
    check("midrst_syn",    syndromeOutputPort,      32'd0);
    check("midrst_err",    32'(errorDetectedPort),  32'd0);
    check("midrst_lenerr", 32'(lengthErrorPort),    32'd0);
    drive(1'b0, 8'h00);
    check("midrst_lenerr_after", 32'(lengthErrorPort), 32'd0);

    // r(x) = x^3 after reset: S_j = alpha^(3j) = 08, 40, 3A, CD.
    set_impulse(12, 8'h01);
    send_frame();
    check_result("post_reset", 32'hCD3A_4008, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_syndrome_calc.md
# rs_syndrome_calc

Syndrome calculator forming the first stage of the Reed-Solomon decoder path, directly downstream of the RS encoder. It consumes the encoder's codeword stream (one symbol per cycle while valid), evaluates the received polynomial at alpha^1..alpha^(2T) over GF(2^8) by Horner accumulation, and presents all 2T syndromes in parallel with a one-cycle valid pulse and an error-detected flag.

## Interface
- SYM_W, 8: symbol width in bits (GF(2^SYM_W))
- CODE_LEN, 16: symbols per codeword frame
- T, 2: correctable symbols; 2T syndromes computed
- clock  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- codewordValidPort  input  1  symbol on codewordInputPort valid this cycle (encoder valid)
- codewordInputPort  input  SYM_W  received symbol, highest-degree coefficient first
- syndromeValidPort  output  1  one-cycle pulse: syndromeOutputPort updated
- syndromeOutputPort  output  2T*SYM_W  S_1 in bits [SYM_W-1:0], S_2T in the top slice
- errorDetectedPort  output  1  any syndrome nonzero; qualified by syndromeValidPort, held thereafter
- lengthErrorPort  output  1  one-cycle pulse: frame ended short (see Configuration)

## Operation
- Clock is `clock`; reset is synchronous and active-high on `reset`.
- FSM: IDLE, ACCUM.
  - IDLE: valid=1 -> accept symbol 1, S_j <= r, count <= 1, go ACCUM.
  - ACCUM: valid=1 -> S_j <= S_j*alpha^j XOR r, count++. On acceptance of symbol CODE_LEN: load output registers from next-state accumulators, pulse syndromeValidPort, count <= 0, go IDLE.
  - ACCUM: valid=0 with count in 1..CODE_LEN-1 -> short frame. Discard accumulators, count <= 0, go IDLE, pulse lengthErrorPort (when enabled).
- GF arithmetic: field polynomial 0x11D, alpha = 0x02, addition = XOR. Constant multiply by alpha^j is combinational.
- Back-to-back frames are required. If valid stays high past symbol CODE_LEN, the next symbol starts a fresh frame in the same cycle the result is published. The first-symbol path takes priority over accumulate.
- Output registers hold the last completed frame until the next completion. A short frame does not disturb them.
- Reset (including mid-frame): FSM IDLE, count 0, accumulators 0, all outputs 0. The partial frame is dropped with no lengthError pulse.

## Timing
- Symbol k is sampled at edge E_k, where valid=1.
- Latency: syndromeValidPort and the new syndromeOutputPort/errorDetectedPort are visible in the cycle after E_CODE_LEN, i.e. registered at the edge that samples the last symbol. No extra pipeline delay.
- syndromeValidPort is high for exactly one cycle per complete frame. It never fires twice within CODE_LEN cycles.
- lengthErrorPort is registered at the first edge sampling valid=0 mid-frame, and is high for one cycle.
- syndromeValidPort and lengthErrorPort are never high together.

## Configuration
- RS_SYNDROME_LEN_CHECK_EN defined: short-frame detection drives lengthErrorPort as above.
- Undefined: lengthErrorPort is tied 0. A short frame is silently discarded; the FSM still returns to IDLE and the accumulators clear.

## Structure
- Shared package rs_pkg: SYM_W default, field polynomial 0x11D, symbol typedef, alpha-power constant table alpha^0..alpha^(2^SYM_W-2), and FSM state enum.
- One sub-module: gf_const_mult (parameter: constant exponent; input symbol; output symbol times alpha^exp). It is instantiated 2T times.

## Test plan
- All-zero 16-symbol frame -> syndromeOutputPort = 0, errorDetectedPort = 0, syndromeValidPort high exactly 1 cycle after the 16th symbol edge.
- Frame of fifteen 0x00 then 0x01 (degree 0) -> S_1..S_4 all 0x01, errorDetectedPort = 1.
- Frame with 0x01 first, then fifteen 0x00 (degree 15) -> S_1 = 0x26 (alpha^15), errorDetectedPort = 1.
- Encoder codeword: 16 symbols from the RS encoder (roots alpha^1..alpha^4) -> all syndromes 0. Then flip one symbol by XOR 0x55 -> errorDetectedPort = 1.
- Two frames back-to-back (valid high 32 cycles): two syndromeValidPort pulses exactly 16 cycles apart, with correct independent results. Outputs held unchanged between the pulses.
- Valid dropped after 7 symbols -> lengthErrorPort pulses once (macro defined) or stays 0 (undefined), with no syndromeValidPort and the prior outputs unchanged. Reset asserted mid-frame -> all outputs 0 next cycle, and a following full frame is computed correctly.
